// File: rtl/hazard_scoreboard_if.sv
// Issue/status bundle between the ID stage and the hazard scoreboard.
// master = ID control side, slave = scoreboard.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 4,
    parameter int STAT_W   = 16
);
    logic                valid;
    logic [REG_AW-1:0]   rs;
    logic [REG_AW-1:0]   rt;
    logic                useRs;
    logic                useRt;
    logic                wr;
    logic [REG_AW-1:0]   rd;
    logic [CNT_W-1:0]    lat;
    logic                isLong;
    logic                branchD;
    logic                flush;
    logic                stall;
    logic                fire;
    logic [NUM_REGS-1:0] pending;
    logic                longBusy;
    logic [STAT_W-1:0]   stallCycles;

    modport master (
        output valid, rs, rt, useRs, useRt, wr, rd,
        output lat, isLong, branchD, flush,
        input  stall, fire, pending, longBusy, stallCycles
    );

    modport slave (
        input  valid, rs, rt, useRs, useRt, wr, rd,
        input  lat, isLong, branchD, flush,
        output stall, fire, pending, longBusy, stallCycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register result countdown scoreboard for ID-stage issue control.
// Blocks issue on RAW, WAW and long-unit structural hazards.
module hazard_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 4,
    parameter int FWD_SLACK = 1,
    parameter int STAT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave sb
);
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [CNT_W-1:0]    longCnt;
    logic [STAT_W-1:0]   stallCnt;
    logic [CNT_W-1:0]    effLat;
    logic [CNT_W-1:0]    thr;
    logic                rawRs;
    logic                rawRt;
    logic                waw;
    logic                structHaz;
    logic                stall;
    logic                fire;
    logic [NUM_REGS-1:0] pend;

    // Branches compare in ID, so they get no forwarding slack.
    always_comb begin
        effLat    = (sb.lat == '0) ? CNT_W'(1) : sb.lat;
        thr       = sb.branchD ? '0 : CNT_W'(FWD_SLACK);
        rawRs     = sb.useRs && (sb.rs != '0) && (cnt[sb.rs] > thr);
        rawRt     = sb.useRt && (sb.rt != '0) && (cnt[sb.rt] > thr);
        waw       = sb.wr && (sb.rd != '0) && (cnt[sb.rd] > effLat);
        structHaz = sb.isLong && (longCnt != '0);
        stall     = rst_n && sb.valid &&
                    (rawRs || rawRt || waw || structHaz);
        fire      = rst_n && sb.valid && !stall && !sb.flush;
    end

    always_comb begin
        pend = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            pend[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            longCnt  <= '0;
            stallCnt <= '0;
        end else begin
            cnt[0] <= '0;
            // A new producer overrides whatever countdown was running.
            for (int r = 1; r < NUM_REGS; r++) begin
                if (fire && sb.wr && (sb.rd == REG_AW'(r))) begin
                    cnt[r] <= effLat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
            if (fire && sb.isLong) begin
                longCnt <= effLat;
            end else if (longCnt != '0) begin
                longCnt <= longCnt - CNT_W'(1);
            end
            if (stall && (stallCnt != '1)) begin
                stallCnt <= stallCnt + STAT_W'(1);
            end
        end
    end

    assign sb.stall       = stall;
    assign sb.fire        = fire;
    assign sb.pending     = pend;
    assign sb.longBusy    = (longCnt != '0);
    assign sb.stallCycles = stallCnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Random + directed bench for hazard_scoreboard against a ready-time model.
module tb_hazard_scoreboard;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic clk;
    logic rst_n;

    hazard_scoreboard_if #(.STAT_W(SW)) bus ();

    hazard_scoreboard #(.STAT_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int k;
    int readyAt [32];
    int longReady;
    int statM;
    bit checking;
    logic eStall;
    logic eFire;
    logic [31:0] ePend;
    logic eLong;
    int effL;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h cycle=%0d", name, act, exp, k);
        end
    endtask

    function automatic int remOf(input int r);
        if (r == 0) return 0;
        return (readyAt[r] > k) ? readyAt[r] - k : 0;
    endfunction

    task automatic cyc(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input bit wr,
                       input logic [4:0] rd, input logic [3:0] lat,
                       input bit lng, input bit br, input bit fl);
        int thr;
        bit hz;
        bus.valid = v; bus.rs = rs; bus.rt = rt;
        bus.useRs = urs; bus.useRt = urt; bus.wr = wr; bus.rd = rd;
        bus.lat = lat; bus.isLong = lng; bus.branchD = br; bus.flush = fl;
        #1;
        effL = (lat == 0) ? 1 : int'(lat);
        thr  = br ? 0 : 1;
        hz = (urs && remOf(int'(rs)) > thr) ||
             (urt && remOf(int'(rt)) > thr) ||
             (wr && remOf(int'(rd)) > effL) ||
             (lng && longReady > k);
        eStall = rst_n && v && hz;
        eFire  = rst_n && v && !hz && !fl;
        for (int r = 0; r < 32; r++) ePend[r] = (remOf(r) > 0);
        eLong = (longReady > k);
        if (checking) begin
            chk("stall", 64'(bus.stall), 64'(eStall));
            chk("fire", 64'(bus.fire), 64'(eFire));
            chk("pending", 64'(bus.pending), 64'(ePend));
            chk("longBusy", 64'(bus.longBusy), 64'(eLong));
            chk("stallCycles", 64'(bus.stallCycles), 64'(statM));
        end
    endtask

    task automatic adv();
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) readyAt[r] = k + 1;
            longReady = k + 1;
            statM = 0;
        end else begin
            if (eStall && statM != SMAX) statM++;
            if (eFire && bus.wr && bus.rd != 0) readyAt[bus.rd] = k + 1 + effL;
            if (eFire && bus.isLong) longReady = k + 1 + effL;
        end
        k++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            adv();
        end
    endtask

    initial begin
        checks = 0; failures = 0; k = 0; statM = 0; longReady = 0;
        checking = 0;
        for (int r = 0; r < 32; r++) readyAt[r] = 0;
        rst_n = 1'b0;
        @(negedge clk);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        adv();
        checking = 1;
        rst_n = 1'b1;
        idle(2);
        chk("reset pending", 64'(bus.pending), 64'd0);
        chk("reset stats", 64'(bus.stallCycles), 64'd0);

        // T1 load-use
        cyc(1, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0);
        chk("T1 prod fire", 64'(bus.fire), 64'd1);
        adv();
        cyc(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("T1 stall", 64'(bus.stall), 64'd1);
        adv();
        cyc(1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("T1 fire", 64'(bus.fire), 64'd1);
        chk("T1 stats", 64'(bus.stallCycles), 64'd1);
        adv();
        idle(4);

        // T2 ALU chain: add forwards, beq waits one cycle
        cyc(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0); adv();
        cyc(1, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("T2 add nostall", 64'(bus.stall), 64'd0);
        adv();
        idle(2);
        cyc(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0); adv();
        cyc(1, 0, 3, 0, 1, 0, 0, 1, 0, 1, 0);
        chk("T2 beq stall", 64'(bus.stall), 64'd1);
        adv();
        cyc(1, 0, 3, 0, 1, 0, 0, 1, 0, 1, 0);
        chk("T2 beq fire", 64'(bus.fire), 64'd1);
        adv();
        idle(4);

        // T3 long unit
        cyc(1, 0, 0, 0, 0, 1, 4, 5, 1, 0, 0); adv();
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
            chk("T3 stall", 64'(bus.stall), 64'd1);
            adv();
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("T3 fire", 64'(bus.fire), 64'd1);
        chk("T3 longBusy", 64'(bus.longBusy), 64'd0);
        adv();
        idle(4);

        // T4 WAW
        cyc(1, 0, 0, 0, 0, 1, 5, 5, 0, 0, 0); adv();
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
            chk("T4 stall", 64'(bus.stall), 64'd1);
            adv();
        end
        cyc(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        chk("T4 fire", 64'(bus.fire), 64'd1);
        chk("T4 pend5", 64'(bus.pending[5]), 64'd1);
        adv();
        idle(16);

        // T5 r0 and flush
        cyc(1, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0); adv();
        cyc(1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0);
        chk("T5 r0 nostall", 64'(bus.stall), 64'd0);
        chk("T5 r0 pend", 64'(bus.pending), 64'd0);
        adv();
        cyc(1, 0, 0, 0, 0, 1, 6, 3, 0, 0, 1);
        chk("T5 flush fire", 64'(bus.fire), 64'd0);
        adv();
        chk("T5 flush pend", 64'(bus.pending), 64'd0);
        idle(2);

        // T6 reset mid-op, hazardous issue while in reset
        cyc(1, 0, 0, 0, 0, 1, 7, 9, 1, 0, 0); adv();
        rst_n = 1'b0;
        cyc(1, 7, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        chk("T6 rst stall", 64'(bus.stall), 64'd0);
        chk("T6 rst fire", 64'(bus.fire), 64'd0);
        adv();
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("T6 pend", 64'(bus.pending), 64'd0);
        chk("T6 long", 64'(bus.longBusy), 64'd0);
        chk("T6 stats", 64'(bus.stallCycles), 64'd0);
        adv();

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(63) != 0);
            cyc($urandom_range(3) != 0,
                5'($urandom_range(7)), 5'($urandom_range(7)),
                $urandom_range(1) == 1, $urandom_range(1) == 1,
                $urandom_range(1) == 1, 5'($urandom_range(7)),
                4'($urandom_range(15)), $urandom_range(3) == 0,
                $urandom_range(3) == 0, $urandom_range(7) == 0);
            adv();
        end
        rst_n = 1'b1;

        // Stats saturation
        rst_n = 1'b0; idle(1); rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0, 15, 1, 0, 0); adv();
        repeat (20) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 15, 1, 0, 0);
            adv();
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("stats saturate", 64'(bus.stallCycles), 64'(SMAX));
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
